// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue stage: scheduler FSM states, fetch entries, register helpers.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package issue_scheduler_pkg;

    // RUN issues normally, DRAIN waits for the pipe to empty ahead of a serializing
    // instruction, SER_WAIT holds everything behind an in-flight serializing instruction.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        SER_WAIT = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A register operand is blocked when it is used, is not x0, and has a pending write.
    function automatic logic reg_pending(input logic [31:0] sb,
                                         input logic        used,
                                         input logic [4:0]  idx);
        return used && (idx != REG_ZERO) && sb[idx];
    endfunction

endpackage

// File: rtl/issue_scheduler_instr_fifo.sv
// Small instruction FIFO holding fetched {instr, pc} entries for the issue stage.
// Latency: 1 cycle push-to-head; head is presented combinationally from storage.
// Backpressure: caller must not push when full; flush empties it at the next edge.
module instr_fifo
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  fetch_entry_t  push_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, dropped immediately on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/issue_scheduler.sv
// Issue stage: buffers fetch, checks decoded registers against a scoreboard, issues one per cycle.
// Latency: an instruction can issue the cycle after it is pushed; writeback unblocks one cycle later.
// Backpressure: fetch_ready_o from registered FIFO count; issue_valid_o is a re-evaluated request.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        flush_i,
    output logic        dec_valid_o,
    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_rs1_v_i,
    input  logic        dec_rs2_v_i,
    input  logic        dec_rd_v_i,
    input  logic        dec_serialize_i,
    output logic        issue_valid_o,
    input  logic        issue_ready_i,
    output logic [31:0] issue_instr_o,
    output logic [31:0] issue_pc_o,
    input  logic        wb_valid_i,
    input  logic        wb_rd_v_i,
    input  logic [4:0]  wb_rd_i,
    output logic        hazard_o,
    output logic        busy_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_in;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;

    logic [31:0]   sb_q, sb_d;
    logic [OW-1:0] out_q, out_d;
    sched_state_t  state_q, state_d;

    logic          hazard;
    logic          permit;
    logic          issue_hs;

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    assign fetch_ready_o = (fifo_count < CW'(DEPTH));
    assign fifo_push     = fetch_valid_i && fetch_ready_o && !flush_i;
    assign fifo_in       = '{instr: fetch_instr_i, pc: fetch_pc_i};

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (fifo_push),
        .push_dat_i (fifo_in),
        .pop_i      (issue_hs),
        .flush_i    (flush_i),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign dec_valid_o   = !fifo_empty;
    assign dec_instr_o   = fifo_head.instr;
    assign dec_pc_o      = fifo_head.pc;
    assign issue_instr_o = fifo_head.instr;
    assign issue_pc_o    = fifo_head.pc;

    // ------------------------------------------------------------------
    // Issue decision
    // ------------------------------------------------------------------
    // RAW on both sources plus WAW on the destination, all against registered state,
    // so a writeback landing this cycle only unblocks the head on the next one.
    assign hazard = reg_pending(sb_q, dec_rs1_v_i, dec_rs1_i)
                  | reg_pending(sb_q, dec_rs2_v_i, dec_rs2_i)
                  | reg_pending(sb_q, dec_rd_v_i,  dec_rd_i);

    // Only RUN may issue; a serializing head additionally needs an empty pipeline.
    assign permit = (state_q == RUN) && (!dec_serialize_i || (out_q == '0));

    assign issue_valid_o = dec_valid_o && !hazard && !flush_i
                         && (out_q < OW'(MAX_OUTSTANDING)) && permit;
    assign issue_hs      = issue_valid_o && issue_ready_i;

    assign hazard_o = dec_valid_o && hazard;
    assign busy_o   = !fifo_empty || (out_q != '0);

    // ------------------------------------------------------------------
    // Scoreboard and outstanding count
    // ------------------------------------------------------------------
    // Set on issue, clear on writeback; x0 is never tracked. The WAW check keeps
    // set and clear from ever targeting the same index in one cycle.
    always_comb begin
        sb_d = sb_q;
        if (issue_hs && dec_rd_v_i && (dec_rd_i != REG_ZERO)) sb_d[dec_rd_i] = 1'b1;
        if (wb_valid_i && wb_rd_v_i && (wb_rd_i != REG_ZERO)) sb_d[wb_rd_i] = 1'b0;
    end

    // Issued-but-not-written-back count; issue and writeback together cancel out.
    always_comb begin
        out_d = out_q;
        if (issue_hs && !wb_valid_i)      out_d = out_q + 1'b1;
        else if (!issue_hs && wb_valid_i) out_d = out_q - 1'b1;
    end

    // ------------------------------------------------------------------
    // Serialization FSM
    // ------------------------------------------------------------------
    // Next state: a serializing head behind older work parks in DRAIN; once it issues
    // we sit in SER_WAIT until it retires. Flush rescues DRAIN but not SER_WAIT, since
    // the serializing instruction is already in execute.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (dec_valid_o && dec_serialize_i) begin
                    if (issue_hs)                        state_d = SER_WAIT;
                    else if (out_q != '0 && !flush_i)    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_i || (out_q == '0))            state_d = RUN;
            end
            SER_WAIT: begin
                if (out_q == '0)                         state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Register update for scoreboard, counter and FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q    <= '0;
            out_q   <= '0;
            state_q <= RUN;
        end else begin
            sb_q    <= sb_d;
            out_q   <= out_d;
            state_q <= state_d;
        end
    end

    // A writeback with nothing outstanding means execute and issue disagree.
    a_wb_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) wb_valid_i |-> (out_q != '0));

    // The full flag and the count must describe the same occupancy.
    a_full_matches_count: assert property (
        @(posedge clk_i) disable iff (rst_i) fifo_full == (fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with a small decoder model and an issue scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next.
// Backpressure: exercised through issue_ready_i and the FIFO-full fetch handshake.
module tb_issue_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic        flush_i;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic        dec_rs1_v_i, dec_rs2_v_i, dec_rd_v_i;
    logic        dec_serialize_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [31:0] issue_instr_o;
    logic [31:0] issue_pc_o;
    logic        wb_valid_i;
    logic        wb_rd_v_i;
    logic [4:0]  wb_rd_i;
    logic        hazard_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issued_n = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;

    localparam logic [31:0] FENCE = 32'h0ff0000f;

    issue_scheduler #(.DEPTH(2), .MAX_OUTSTANDING(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .fetch_instr_i   (fetch_instr_i),
        .fetch_pc_i      (fetch_pc_i),
        .flush_i         (flush_i),
        .dec_valid_o     (dec_valid_o),
        .dec_instr_o     (dec_instr_o),
        .dec_pc_o        (dec_pc_o),
        .dec_rs1_i       (dec_rs1_i),
        .dec_rs2_i       (dec_rs2_i),
        .dec_rd_i        (dec_rd_i),
        .dec_rs1_v_i     (dec_rs1_v_i),
        .dec_rs2_v_i     (dec_rs2_v_i),
        .dec_rd_v_i      (dec_rd_v_i),
        .dec_serialize_i (dec_serialize_i),
        .issue_valid_o   (issue_valid_o),
        .issue_ready_i   (issue_ready_i),
        .issue_instr_o   (issue_instr_o),
        .issue_pc_o      (issue_pc_o),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_v_i       (wb_rd_v_i),
        .wb_rd_i         (wb_rd_i),
        .hazard_o        (hazard_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    // Minimal RV32 decoder: OP-IMM, OP, and the serializing MISC-MEM / SYSTEM groups.
    always_comb begin
        dec_rs1_i       = dec_instr_o[19:15];
        dec_rs2_i       = dec_instr_o[24:20];
        dec_rd_i        = dec_instr_o[11:7];
        dec_rs1_v_i     = 1'b0;
        dec_rs2_v_i     = 1'b0;
        dec_rd_v_i      = 1'b0;
        dec_serialize_i = 1'b0;
        case (dec_instr_o[6:0])
            7'b0010011: begin dec_rs1_v_i = 1'b1; dec_rd_v_i = 1'b1; end
            7'b0110011: begin dec_rs1_v_i = 1'b1; dec_rs2_v_i = 1'b1; dec_rd_v_i = 1'b1; end
            7'b0001111, 7'b1110011: dec_serialize_i = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one instruction to the DUT and hold it until the FIFO takes it.
    task automatic push1(input logic [31:0] pc, input logic [31:0] instr);
        int n = 0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        fetch_instr_i = instr;
        #1;
        while (!fetch_ready_o && n < 50) begin
            step();
            n++;
        end
        chk("push_accept", {31'b0, fetch_ready_o}, 32'd1);
        exp_q.push_back({pc, instr});
        step();
        fetch_valid_i = 1'b0;
    endtask

    task automatic wb_pulse(input logic rd_v, input logic [4:0] rd);
        wb_valid_i = 1'b1;
        wb_rd_v_i  = rd_v;
        wb_rd_i    = rd;
        step();
        wb_valid_i = 1'b0;
        wb_rd_v_i  = 1'b0;
        wb_rd_i    = 5'd0;
    endtask

    // Issue monitor: every accepted issue must be the oldest expected instruction.
    always @(negedge clk_i) begin
        if (!rst_i && issue_valid_o && issue_ready_i) begin
            issued_n++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_order: got pc %08h instr %08h, required no issue", issue_pc_o, issue_instr_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({issue_pc_o, issue_instr_o} !== mon_e)
                begin
                    bad++;
                    $display("FAIL issue_order: got pc %08h instr %08h, required pc %08h instr %08h",
                             issue_pc_o, issue_instr_o, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_i = 1'b1;
        fetch_valid_i = 1'b0; fetch_instr_i = '0; fetch_pc_i = '0;
        flush_i = 1'b0; issue_ready_i = 1'b1;
        wb_valid_i = 1'b0; wb_rd_v_i = 1'b0; wb_rd_i = '0;
        repeat (3) step();
        chk("rst_dec_valid",   {31'b0, dec_valid_o},   32'd0);
        chk("rst_issue_valid", {31'b0, issue_valid_o}, 32'd0);
        chk("rst_hazard",      {31'b0, hazard_o},      32'd0);
        chk("rst_busy",        {31'b0, busy_o},        32'd0);
        chk("rst_fetch_ready", {31'b0, fetch_ready_o}, 32'd1);
        rst_i = 1'b0;
        step();

        // 1. RAW stall on x5
        push1(32'h100, addi(5'd5, 5'd0, 12'd1));
        push1(32'h104, add(5'd6, 5'd5, 5'd5));
        #1;
        chk("raw_hazard",  {31'b0, hazard_o},      32'd1);
        chk("raw_blocked", {31'b0, issue_valid_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("raw_hold", {31'b0, hazard_o}, 32'd1);
        end
        wb_valid_i = 1'b1; wb_rd_v_i = 1'b1; wb_rd_i = 5'd5;
        #1;
        chk("raw_wb_same_cycle", {31'b0, issue_valid_o}, 32'd0);
        step();
        wb_valid_i = 1'b0; wb_rd_v_i = 1'b0; wb_rd_i = 5'd0;
        #1;
        chk("raw_after_wb_hazard", {31'b0, hazard_o},      32'd0);
        chk("raw_after_wb_issue",  {31'b0, issue_valid_o}, 32'd1);
        step();
        wb_pulse(1'b1, 5'd6);

        // 2. x0 is never a hazard
        push1(32'h200, addi(5'd0, 5'd0, 12'd1));
        push1(32'h204, add(5'd1, 5'd0, 5'd0));
        #1;
        chk("x0_hazard", {31'b0, hazard_o},      32'd0);
        chk("x0_issue",  {31'b0, issue_valid_o}, 32'd1);
        step();
        chk("x0_back_to_back", last_cyc - prev_cyc, 32'd1);
        wb_pulse(1'b1, 5'd0);
        wb_pulse(1'b1, 5'd1);

        // 3. Serializing fence behind two outstanding adds
        push1(32'h300, add(5'd10, 5'd0, 5'd0));
        push1(32'h304, add(5'd11, 5'd0, 5'd0));
        push1(32'h308, FENCE);
        push1(32'h30c, addi(5'd12, 5'd0, 12'd1));
        #1;
        chk("ser_drain_block", {31'b0, issue_valid_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("ser_drain_hold", {31'b0, issue_valid_o}, 32'd0);
        end
        wb_pulse(1'b1, 5'd10);
        #1;
        chk("ser_drain_wb1", {31'b0, issue_valid_o}, 32'd0);
        wb_pulse(1'b1, 5'd11);
        #1;
        chk("ser_drain_wb2", {31'b0, issue_valid_o}, 32'd0);
        step();
        chk("ser_fence_issue", {31'b0, issue_valid_o}, 32'd1);
        chk("ser_fence_pc",    dec_pc_o,               32'h308);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("ser_wait_hold", {31'b0, issue_valid_o}, 32'd0);
            step();
        end
        wb_pulse(1'b0, 5'd0);
        #1;
        chk("ser_wait_after_wb", {31'b0, issue_valid_o}, 32'd0);
        step();
        chk("ser_addi_issue", {31'b0, issue_valid_o}, 32'd1);
        step();
        wb_pulse(1'b1, 5'd12);

        // 4. FIFO full with execute stalled
        issue_ready_i = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i = 32'h0; fetch_instr_i = addi(5'd20, 5'd0, 12'd1);
        #1;
        chk("full_ready0", {31'b0, fetch_ready_o}, 32'd1);
        exp_q.push_back({fetch_pc_i, fetch_instr_i});
        step();
        fetch_pc_i = 32'h4; fetch_instr_i = addi(5'd21, 5'd0, 12'd1);
        #1;
        chk("full_ready1", {31'b0, fetch_ready_o}, 32'd1);
        exp_q.push_back({fetch_pc_i, fetch_instr_i});
        step();
        fetch_pc_i = 32'h8; fetch_instr_i = addi(5'd22, 5'd0, 12'd1);
        #1;
        chk("full_ready2", {31'b0, fetch_ready_o}, 32'd0);
        step();
        chk("full_held",     {31'b0, fetch_ready_o}, 32'd0);
        chk("full_head_pc",  dec_pc_o,               32'h0);
        issue_ready_i = 1'b1;
        #1;
        chk("full_no_bypass", {31'b0, fetch_ready_o}, 32'd0);
        step();
        chk("full_reopen", {31'b0, fetch_ready_o}, 32'd1);
        exp_q.push_back({fetch_pc_i, fetch_instr_i});
        step();
        fetch_valid_i = 1'b0;
        step();
        wb_pulse(1'b1, 5'd20);
        wb_pulse(1'b1, 5'd21);
        wb_pulse(1'b1, 5'd22);
        #1;
        chk("full_idle", {31'b0, busy_o}, 32'd0);

        // 5. Outstanding limit of four
        base = issued_n;
        for (int i = 1; i <= 5; i++)
            push1(32'h500 + 32'(4 * (i - 1)), addi(5'(i), 5'd0, 12'd1));
        #1;
        chk("lim_block",  {31'b0, issue_valid_o}, 32'd0);
        chk("lim_hazard", {31'b0, hazard_o},      32'd0);
        step();
        chk("lim_count", issued_n - base, 32'd4);
        wb_valid_i = 1'b1; wb_rd_v_i = 1'b1; wb_rd_i = 5'd1;
        #1;
        chk("lim_wb_same_cycle", {31'b0, issue_valid_o}, 32'd0);
        step();
        wb_valid_i = 1'b0; wb_rd_v_i = 1'b0; wb_rd_i = 5'd0;
        #1;
        chk("lim_fifth_issue", {31'b0, issue_valid_o}, 32'd1);
        step();
        for (int i = 2; i <= 5; i++) wb_pulse(1'b1, 5'(i));

        // 6a. Flush drops queued entries but keeps the scoreboard
        push1(32'h600, addi(5'd7, 5'd0, 12'd1));
        step();
        issue_ready_i = 1'b0;
        push1(32'h604, addi(5'd9, 5'd0, 12'd1));
        push1(32'h608, addi(5'd13, 5'd0, 12'd1));
        #1;
        chk("flush_full", {31'b0, fetch_ready_o}, 32'd0);
        flush_i = 1'b1;
        issue_ready_i = 1'b1;
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h700; fetch_instr_i = addi(5'd2, 5'd0, 12'd1);
        #1;
        chk("flush_no_issue", {31'b0, issue_valid_o}, 32'd0);
        exp_q.delete();
        step();
        flush_i = 1'b0;
        fetch_valid_i = 1'b0;
        #1;
        chk("flush_empty",  {31'b0, dec_valid_o},   32'd0);
        chk("flush_ready",  {31'b0, fetch_ready_o}, 32'd1);
        chk("flush_busy",   {31'b0, busy_o},        32'd1);
        push1(32'h60c, add(5'd14, 5'd7, 5'd0));
        #1;
        chk("flush_sb7_kept", {31'b0, hazard_o}, 32'd1);
        wb_pulse(1'b1, 5'd7);
        #1;
        chk("flush_sb7_cleared", {31'b0, issue_valid_o}, 32'd1);
        step();
        wb_pulse(1'b1, 5'd14);

        // 6b. Reset while draining toward a fence
        push1(32'h800, add(5'd15, 5'd0, 5'd0));
        push1(32'h804, FENCE);
        step();
        chk("rdrain_block", {31'b0, issue_valid_o}, 32'd0);
        chk("rdrain_busy",  {31'b0, busy_o},        32'd1);
        rst_i = 1'b1;
        #1;
        chk("mrst_dec_valid",   {31'b0, dec_valid_o},   32'd0);
        chk("mrst_issue_valid", {31'b0, issue_valid_o}, 32'd0);
        chk("mrst_hazard",      {31'b0, hazard_o},      32'd0);
        chk("mrst_busy",        {31'b0, busy_o},        32'd0);
        chk("mrst_fetch_ready", {31'b0, fetch_ready_o}, 32'd1);
        exp_q.delete();
        step();
        rst_i = 1'b0;
        step();
        push1(32'h900, add(5'd16, 5'd15, 5'd0));
        #1;
        chk("mrst_sb_cleared", {31'b0, hazard_o},      32'd0);
        chk("mrst_issue",      {31'b0, issue_valid_o}, 32'd1);
        step();
        wb_pulse(1'b1, 5'd16);

        #1;
        chk("end_queue_empty", exp_q.size(), 32'd0);
        chk("end_idle", {31'b0, busy_o}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
